timepulse_sequencer: RTL

Generates the one-hot time-pulse train (T01..T12) that sequences the NOR-gate datapath through each memory cycle time (MCT).
- Supports free-run, run/stop, a mid-cycle stall at T06 for memory wait, and single-MCT stepping for the monitor.
- Sits between the clock/reset logic and the control-pulse decoders; every datapath gate enable is qualified by one of its `tp` bits.

---
 rtl/timepulse_sequencer_if.sv | 26 ++
 rtl/timepulse_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/timepulse_sequencer_if.sv
// Handshake bundle between the time-pulse sequencer and its controller/monitor.
// The sequencer attaches through the slave modport; the driver of run/stall/step uses master.
interface timepulse_sequencer_if #(
  parameter int NUM_PULSES = 12,
  parameter int CNT_W      = 16
);
  logic                  run;
  logic                  stall;
  logic                  step_mode;
  logic                  step_req;
  logic [NUM_PULSES-1:0] tp;
  logic                  mct_end;
  logic [CNT_W-1:0]      mct_count;
  logic                  parked;
  logic [1:0]            state;

  modport master (
    output run, stall, step_mode, step_req,
    input  tp, mct_end, mct_count, parked, state
  );

  modport slave (
    input  run, stall, step_mode, step_req,
    output tp, mct_end, mct_count, parked, state
  );
endinterface

// File: rtl/timepulse_sequencer.sv
// One-hot T01..Tn time-pulse generator for the NOR-gate datapath memory cycle (MCT),
// with run/stop, a memory-wait hold at STALL_PULSE and single-MCT stepping.
module timepulse_sequencer #(
  parameter int NUM_PULSES  = 12,
  parameter int STALL_PULSE = 6,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  timepulse_sequencer_if.slave bus
);

  if (NUM_PULSES < 2) begin : g_chk_np
    $error("NUM_PULSES must be at least 2");
  end
  if ((STALL_PULSE < 1) || (STALL_PULSE > NUM_PULSES - 1)) begin : g_chk_sp
    $error("STALL_PULSE must lie in 1..NUM_PULSES-1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PARK = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  localparam logic [NUM_PULSES-1:0] T01     = NUM_PULSES'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  state_e                state_q, state_d;
  logic [NUM_PULSES-1:0] tp_q, tp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  step_prev_q;

  logic                  step_rise;
  logic                  at_end;
  logic                  at_stall;
  logic [NUM_PULSES-1:0] tp_adv;

  assign step_rise = bus.step_req & ~step_prev_q;
  assign at_end    = tp_q[NUM_PULSES-1];
  assign at_stall  = tp_q[STALL_PULSE-1];
  assign tp_adv    = {tp_q[NUM_PULSES-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tp_q        <= '0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tp_q        <= tp_d;
      cnt_q       <= cnt_d;
      step_prev_q <= bus.step_req;
    end
  end

  // An MCT, once started, always runs to the last pulse; run/step_mode only
  // matter at the MCT boundary, and run is ignored while held for memory.
  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_RUN;
          tp_d    = T01;
        end
      end
      ST_RUN: begin
        if (at_end) begin
          cnt_d = cnt_q + CNT_ONE;
          if (!bus.run) begin
            state_d = ST_IDLE;
            tp_d    = '0;
          end else if (bus.step_mode) begin
            state_d = ST_PARK;
            tp_d    = '0;
          end else begin
            tp_d    = T01;
          end
        end else if (at_stall && bus.stall) begin
          state_d = ST_HOLD;
        end else begin
          tp_d    = tp_adv;
        end
      end
      ST_HOLD: begin
        if (!bus.stall) begin
          state_d = ST_RUN;
          tp_d    = tp_adv;
        end
      end
      ST_PARK: begin
        if (!bus.run) begin
          state_d = ST_IDLE;
        end else if (!bus.step_mode || step_rise) begin
          state_d = ST_RUN;
          tp_d    = T01;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tp_d    = '0;
      end
    endcase
  end

  assign bus.tp        = tp_q;
  assign bus.mct_end   = tp_q[NUM_PULSES-1];
  assign bus.mct_count = cnt_q;
  assign bus.parked    = (state_q == ST_PARK);
  assign bus.state     = state_q;

  a_tp_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(tp_q));

  a_tp_zero_state: assert property (@(posedge clk) disable iff (rst)
    ((tp_q == '0) == ((state_q == ST_IDLE) || (state_q == ST_PARK))));

  a_cnt_at_end: assert property (@(posedge clk) disable iff (rst)
    (cnt_q != $past(cnt_q)) |-> $past(at_end));

endmodule
